freq_meter: RTL and testbench

Measures the frequency of an asynchronous square-wave input by counting its rising edges over a 1-second gate timed from `clk_in`. It is the reading end of the team's clock-divider outputs: it checks divider outputs and external signals on the board and feeds the seven-segment display path. Single-shot or continuous operation; the result is reported as binary, plus optional BCD.

---
 rtl/freq_meter_pkg.sv | 37 +++
 rtl/freq_meter_sig_sync.sv | 36 +++
 rtl/freq_meter.sv | 150 +++++++++++++++
 tb/tb_freq_meter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM state encoding and
// the decade-counter helpers used when FREQ_METER_BCD_EN is defined.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int          BCD_DIGITS   = 6;
  localparam int          BCD_MAX      = 999999;
  localparam logic [23:0] BCD_MAX_CODE = 24'h999999;

  // Ripple-carry increment across the decade digits; holds at 999999.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX_CODE) begin
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_sig_sync.sv
// Brings the asynchronous measured signal into the clk_in domain through two
// flops and flags each rising edge with a single-cycle edge_p.
module sig_sync_edge
  import freq_meter_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic edge_p
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign edge_p = sync2_q & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over CLK_HZ clk_in cycles.
// Defining FREQ_METER_BCD_EN adds parallel decade counters and the bcd_out port.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 20
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq_out,
  output logic             overflow
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [23:0]      bcd_out
`endif
);

  localparam int                GATE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Returns {hit_max, next}; next never wraps past CNT_MAX.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return {1'b1, v};
    end
    return {1'b0, v + CNT_W'(1)};
  endfunction

  logic edge_p;

  sig_sync_edge u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .edge_p (edge_p)
  );

  state_e             state_q,    state_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               sat_q,      sat_d;
  logic [CNT_W-1:0]   freq_q,     freq_d;
  logic               ovf_q,      ovf_d;
  logic               sat_hit;
`ifdef FREQ_METER_BCD_EN
  logic [23:0]        bcd_cnt_q,  bcd_cnt_d;
  logic [23:0]        bcd_q,      bcd_d;
`endif

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    sat_hit    = 1'b0;
`ifdef FREQ_METER_BCD_EN
    bcd_cnt_d  = bcd_cnt_q;
    bcd_d      = bcd_q;
`endif
    case (state_q)
      IDLE: begin
        if (start || cont) begin
          state_d = ARM;
        end
      end
      ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
`ifdef FREQ_METER_BCD_EN
        bcd_cnt_d  = '0;
`endif
        state_d    = GATE;
      end
      GATE: begin
        if (edge_p) begin
          {sat_hit, edge_cnt_d} = sat_inc(edge_cnt_q);
          sat_d = sat_q | sat_hit;
`ifdef FREQ_METER_BCD_EN
          bcd_cnt_d = bcd_inc(bcd_cnt_q);
`endif
        end
        // Results take the _d values so an edge in the final gate cycle counts.
        if (gate_cnt_q == GATE_LAST) begin
          state_d = DONE;
          freq_d  = edge_cnt_d;
          ovf_d   = sat_d;
`ifdef FREQ_METER_BCD_EN
          bcd_d   = bcd_cnt_d;
`endif
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      DONE: begin
        state_d = cont ? ARM : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef FREQ_METER_BCD_EN
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      bcd_cnt_q <= '0;
      bcd_q     <= '0;
    end else begin
      bcd_cnt_q <= bcd_cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bcd_out = bcd_q;
`endif

  assign busy     = (state_q != IDLE);
  assign valid    = (state_q == DONE);
  assign freq_out = freq_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: expected counts come from the
// driven waveform and the edge-window timing rule, checked when valid appears.
module tb_freq_meter;
  localparam int CLK_HZ = 1000;
`ifdef FREQ_METER_BCD_EN
  localparam int CNT_W = 20;
`else
  localparam int CNT_W = 8;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             sig_in = 1'b0;
  logic             start  = 1'b0;
  logic             cont   = 1'b0;
  logic             busy, valid, overflow;
  logic [CNT_W-1:0] freq_out;
`ifdef FREQ_METER_BCD_EN
  logic [23:0]      bcd_out;
`endif

  freq_meter #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .sig_in   (sig_in),
    .start    (start),
    .cont     (cont),
    .busy     (busy),
    .valid    (valid),
    .freq_out (freq_out),
    .overflow (overflow)
`ifdef FREQ_METER_BCD_EN
    ,
    .bcd_out  (bcd_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Waveform description: 0 = low, 1 = periodic, 2 = single 4-cycle pulse.
  int wmode = 0;
  int per_v = 10, hi_v = 5, ph_v = 0, px_v = 0;

  function automatic logic sig_val(input int c);
    case (wmode)
      1: return (((c - ph_v) % per_v + per_v) % per_v) < hi_v;
      2: return (c >= px_v) && (c < px_v + 4);
      default: return 1'b0;
    endcase
  endfunction

  // sig_val(n) is driven during the cycle after posedge n.
  initial forever begin
    @(negedge clk_in);
    sig_in = sig_val(cyc);
  end

  typedef struct {
    int               vcyc;
    logic [CNT_W-1:0] f;
    logic             o;
    logic             single;
    logic [23:0]      b;
  } exp_t;
  exp_t sb[$];
  logic [CNT_W-1:0] last_f = '0;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // A rise set up before posedge n+1 is counted at posedge n+3; with start
  // sampled at posedge k, counting posedges are k+2 .. k+CLK_HZ+1.
  function automatic int ref_count(input int k);
    int n_e = 0;
    for (int n = k - 1; n <= k + CLK_HZ - 2; n++)
      if (sig_val(n) && !sig_val(n - 1)) n_e++;
    return n_e;
  endfunction

  task automatic push_exp(input int k, input logic single);
    exp_t e;
    int   c;
    c        = ref_count(k);
    e.vcyc   = k + CLK_HZ + 1;
    e.f      = (c > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(c);
    e.o      = (c > CNT_MAX);
    e.b      = to_bcd((c > 999999) ? 999999 : c);
    e.single = single;
    last_f   = e.f;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst && valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got valid with freq_out %0d, expected none (cyc %0d)",
                   freq_out, cyc);
        end else begin
          e = sb.pop_front();
          check("valid_cycle", cyc, e.vcyc);
          check("freq_out", 32'(freq_out), 32'(e.f));
          check("overflow", 32'(overflow), 32'(e.o));
`ifdef FREQ_METER_BCD_EN
          check("bcd_out", 32'(bcd_out), 32'(e.b));
`endif
          @(negedge clk_in);
          check("valid_width", 32'(valid), 0);
          if (e.single) check("busy_after_done", 32'(busy), 0);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * CLK_HZ && (sb.size() != 0 || busy); i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    if (sb.size() != 0 || busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results busy=%0d, expected 0 pending and idle",
               sb.size(), busy);
      sb.delete();
    end
    check("freq_hold", 32'(freq_out), 32'(last_f));
  endtask

  // Configure the waveform, then launch one measurement sampled at posedge k.
  task automatic measure(input int mode, input int p, input int h, input int ph, input int off);
    int k;
    @(negedge clk_in);
    k     = cyc + 4;
    wmode = mode;
    per_v = p;
    hi_v  = h;
    ph_v  = ph;
    px_v  = k + off;
    wait_cyc(k - 1);
    start = 1'b1;
    push_exp(k, 1'b1);
    @(negedge clk_in);
    start = 1'b0;
    check("busy_in_arm", 32'(busy), 1);
    wait_idle();
  endtask

  initial begin
    int k, p, h;
    #2 rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_freq", 32'(freq_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    repeat (2) @(negedge clk_in);

    measure(1, 10, 5, 0, 0);
    measure(1, 4, 2, 1, 0);
    measure(1, 3, 1, 0, 0);
    measure(1, 2, 1, 0, 0);

    // Single pulses around the gate boundaries.
    measure(2, 1, 1, 0, -2);
    measure(2, 1, 1, 0, -1);
    measure(2, 1, 1, 0, CLK_HZ - 2);
    measure(2, 1, 1, 0, CLK_HZ - 1);

    // Continuous mode: three back-to-back gates, stray start pulses ignored.
    @(negedge clk_in);
    k     = cyc + 4;
    wmode = 1;
    per_v = 20;
    hi_v  = 10;
    ph_v  = $urandom_range(0, 19);
    wait_cyc(k - 1);
    cont = 1'b1;
    push_exp(k, 1'b0);
    push_exp(k + (CLK_HZ + 2), 1'b0);
    push_exp(k + 2 * (CLK_HZ + 2), 1'b1);
    wait_cyc(k + 300);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    wait_cyc(k + (CLK_HZ + 2) + 500);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    wait_cyc(k + 2 * (CLK_HZ + 2) + 10);
    cont = 1'b0;
    wait_idle();

    // Reset in the middle of a gate.
    @(negedge clk_in);
    k     = cyc + 4;
    wmode = 1;
    per_v = 7;
    hi_v  = 3;
    wait_cyc(k - 1);
    start = 1'b1;
    push_exp(k, 1'b1);
    @(negedge clk_in);
    start = 1'b0;
    wait_cyc(k + 1 + 500);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_freq", 32'(freq_out), 0);
    check("abort_ovf", 32'(overflow), 0);
    sb.delete();
    last_f = '0;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    repeat (CLK_HZ + 100) @(negedge clk_in);
    check("abort_freq_held", 32'(freq_out), 0);
    measure(1, 10, 4, 3, 0);

    for (int t = 0; t < 5; t++) begin
      p = $urandom_range(4, 40);
      h = $urandom_range(2, p - 2);
      measure(1, p, h, $urandom_range(0, p - 1), 0);
    end

    repeat (5) @(negedge clk_in);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded its time limit at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
